gpr_wb_arbiter: RTL

- Shares the single GPR write port between the in-order pipeline writeback and the long-latency unit (mul/div/load-miss) result return.
- Buffers long-unit results in a small FIFO and keeps a 32-bit scoreboard of registers with outstanding long-unit writes.
- The scoreboard drives decode hazard detection.
- Sits between the writeback stage / long unit and the GPR write inputs (write enable, address, data, overflow enable, overflow flag).

---
 rtl/gpr_wb_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: shares the single register-file write port between
// the in-order pipeline writeback and results returning from the long-latency
// unit. Long-unit results wait in a small FIFO. A scoreboard tracks registers
// with long-unit writes still outstanding and feeds decode hazard detection.
// A starvation counter briefly stalls the pipeline so the FIFO always drains.
module gpr_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_addr,
  input  logic [31:0] pipe_wr_data,
  input  logic        pipe_of_en,
  input  logic        pipe_of_flag,
  output logic        pipe_stall,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        gpr_wr_en,
  output logic [4:0]  gpr_wr_addr,
  output logic [31:0] gpr_wr_data,
  output logic        gpr_of_en,
  output logic        gpr_of_flag,
  output logic        issue_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  // FIFO storage carries data only; it needs no reset.
  logic [4:0]  addrMem [DEPTH];
  logic [31:0] dataMem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic [3:0]  starveCnt;
  logic        stallQ;
  logic [31:0] pending;
  logic        issueErr;

  logic        full;
  logic        empty;
  logic        push;
  logic        pipeSlot;
  logic        pipeGrant;
  logic        fifoGrant;
  logic        fifoBlocked;
  logic [4:0]  headAddr;
  logic [31:0] headData;
  logic [31:0] setMask;
  logic [31:0] clrMask;
  logic [31:0] pendingNext;
  logic        issueConflict;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  // Readiness ignores a same-cycle pop so it never depends on the grant.
  assign lu_ready = !rst && !full;
  assign push     = lu_valid && lu_ready;
  assign headAddr = addrMem[rdPtr[AW-1:0]];
  assign headData = dataMem[rdPtr[AW-1:0]];

  // Writes to r0 and overflow-trapped writes leave the port free for the FIFO.
  assign pipeSlot = pipe_wr_en && (pipe_wr_addr != 5'd0) && !(pipe_of_en && pipe_of_flag);

  // Port grant: a forced stall cycle belongs to the FIFO, else the pipeline wins.
  always_comb begin
    pipeGrant = 1'b0;
    fifoGrant = 1'b0;
    if (!rst) begin
      if (stallQ) begin
        fifoGrant = !empty;
      end else if (pipeSlot) begin
        pipeGrant = 1'b1;
      end else begin
        fifoGrant = !empty;
      end
    end
  end

  assign fifoBlocked = !empty && !fifoGrant;

  assign gpr_wr_en   = pipeGrant || fifoGrant;
  assign gpr_wr_addr = fifoGrant ? headAddr : pipe_wr_addr;
  assign gpr_wr_data = fifoGrant ? headData : pipe_wr_data;
  // Overflow update passes through unless the pipeline is being held.
  assign gpr_of_en   = !rst && !stallQ && pipe_of_en;
  assign gpr_of_flag = pipe_of_flag;
  assign pipe_stall  = stallQ;

  // Scoreboard update: a new issue outranks a same-cycle retirement.
  always_comb begin
    setMask = 32'd0;
    clrMask = 32'd0;
    if (lu_issue && (lu_issue_addr != 5'd0)) begin
      setMask = 32'd1 << lu_issue_addr;
    end
    if (fifoGrant) begin
      clrMask = 32'd1 << headAddr;
    end
    pendingNext    = ((pending & ~clrMask) | setMask) & ~32'd1;
    issueConflict  = |(setMask & pending & ~clrMask);
  end

  assign hazard    = pending[chk_rs] | pending[chk_rt] | pending[chk_rd];
  assign issue_err = issueErr;

  // FIFO payload write.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr[AW-1:0]] <= lu_addr;
      dataMem[wrPtr[AW-1:0]] <= lu_data;
    end
  end

  // Control state: FIFO pointers, starvation tracking, scoreboard, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      starveCnt <= 4'd0;
      stallQ    <= 1'b0;
      pending   <= 32'd0;
      issueErr  <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (fifoGrant) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (fifoBlocked && (starveCnt == LIMIT_M1)) begin
        stallQ    <= 1'b1;
        starveCnt <= 4'd0;
      end else if (fifoBlocked) begin
        stallQ    <= 1'b0;
        starveCnt <= starveCnt + 4'd1;
      end else begin
        stallQ    <= 1'b0;
        starveCnt <= 4'd0;
      end
      pending <= pendingNext;
      if (issueConflict) begin
        issueErr <= 1'b1;
      end
    end
  end

endmodule
